// File: rtl/controlador_busca_multicanal.sv
// Search controller for the path-finding core: init, active check,
// multi-channel expand, path build, hand-off, with abort/limit/watchdog.
// Ports: clk, rst_n; iniciar_in, abortar_in, tem_ativo_in,
//   canal_habilitado_in[N], lvv_pronto_in[N], caminho_pronto_in, lido_in;
//   aguardando_out, iniciar_out, tem_ativo_out, expandir_out[N],
//   construir_caminho_out, caminho_pronto_out, erro_out,
//   codigo_erro_out[2], iteracoes_out[ITER_WIDTH].
module controlador_busca_multicanal #(
  parameter int N_CANAIS       = 4,
  parameter int ITER_WIDTH     = 16,
  parameter int MAX_ITER       = 1000,
  parameter int TIMEOUT_WIDTH  = 12,
  parameter int TIMEOUT_CICLOS = 4000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iniciar_in,
  input  logic                  abortar_in,
  input  logic                  tem_ativo_in,
  input  logic [N_CANAIS-1:0]   canal_habilitado_in,
  input  logic [N_CANAIS-1:0]   lvv_pronto_in,
  input  logic                  caminho_pronto_in,
  input  logic                  lido_in,
  output logic                  aguardando_out,
  output logic                  iniciar_out,
  output logic                  tem_ativo_out,
  output logic [N_CANAIS-1:0]   expandir_out,
  output logic                  construir_caminho_out,
  output logic                  caminho_pronto_out,
  output logic                  erro_out,
  output logic [1:0]            codigo_erro_out,
  output logic [ITER_WIDTH-1:0] iteracoes_out
);

  typedef enum logic [2:0] {
    IDLE,
    INICIALIZAR,
    TEM_ATIVO,
    EXPANDIR,
    CONSTRUIR,
    PRONTO,
    ERRO
  } estado_t;

  localparam logic [ITER_WIDTH-1:0] L_MAX =
    ITER_WIDTH'(MAX_ITER);
  localparam logic [TIMEOUT_WIDTH-1:0] L_TMO =
    TIMEOUT_WIDTH'(TIMEOUT_CICLOS - 1);

  estado_t                r_estado;
  estado_t                w_prox;
  logic [ITER_WIDTH-1:0]  r_iter;
  logic [TIMEOUT_WIDTH-1:0] r_wd;
  logic [N_CANAIS-1:0]    r_pend;
  logic [N_CANAIS-1:0]    r_exp;
  logic [1:0]             r_cod;

  logic                   w_cod_set;
  logic [1:0]             w_cod_val;
  logic                   w_temporizado;
  logic                   w_abortavel;
  logic                   w_entra_exp;

  always_comb begin
    w_temporizado = (r_estado == INICIALIZAR) ||
                    (r_estado == EXPANDIR) ||
                    (r_estado == CONSTRUIR);
    w_abortavel = w_temporizado || (r_estado == TEM_ATIVO);
  end

  always_comb begin
    w_prox    = r_estado;
    w_cod_set = 1'b0;
    w_cod_val = 2'b00;
    if (iniciar_in) begin
      w_prox = INICIALIZAR;
    end else if (abortar_in && w_abortavel) begin
      w_prox    = ERRO;
      w_cod_set = 1'b1;
      w_cod_val = 2'b01;
    end else if (w_temporizado && (r_wd == L_TMO)) begin
      w_prox    = ERRO;
      w_cod_set = 1'b1;
      w_cod_val = 2'b11;
    end else begin
      case (r_estado)
        INICIALIZAR: if (tem_ativo_in) w_prox = TEM_ATIVO;
        TEM_ATIVO: begin
          if (!tem_ativo_in) begin
            w_prox = CONSTRUIR;
          end else if (r_iter == L_MAX) begin
            w_prox    = ERRO;
            w_cod_set = 1'b1;
            w_cod_val = 2'b10;
          end else if (canal_habilitado_in == '0) begin
            w_prox    = ERRO;
            w_cod_set = 1'b1;
            w_cod_val = 2'b00;
          end else begin
            w_prox = EXPANDIR;
          end
        end
        // A pulse arriving this very cycle already counts.
        EXPANDIR:
          if ((r_pend & ~lvv_pronto_in) == '0) w_prox = TEM_ATIVO;
        CONSTRUIR: if (caminho_pronto_in) w_prox = PRONTO;
        PRONTO:    if (lido_in) w_prox = IDLE;
        ERRO:      if (lido_in) w_prox = IDLE;
        default:   w_prox = r_estado;
      endcase
    end
  end

  assign w_entra_exp = (r_estado == TEM_ATIVO) &&
                       (w_prox == EXPANDIR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
      r_iter   <= '0;
      r_wd     <= '0;
      r_pend   <= '0;
      r_exp    <= '0;
      r_cod    <= 2'b00;
    end else begin
      r_estado <= w_prox;
      r_exp    <= w_entra_exp ? canal_habilitado_in : '0;
      if (iniciar_in)
        r_iter <= '0;
      else if (w_entra_exp)
        r_iter <= r_iter + ITER_WIDTH'(1);
      if (iniciar_in)
        r_cod <= 2'b00;
      else if (w_cod_set)
        r_cod <= w_cod_val;
      // iniciar_in in INICIALIZAR restarts the watchdog too.
      if (iniciar_in || (w_prox != r_estado))
        r_wd <= '0;
      else if (w_temporizado)
        r_wd <= r_wd + TIMEOUT_WIDTH'(1);
      else
        r_wd <= '0;
      if (w_entra_exp)
        r_pend <= canal_habilitado_in;
      else if (w_prox == EXPANDIR)
        r_pend <= r_pend & ~lvv_pronto_in;
      else
        r_pend <= '0;
    end
  end

  assign aguardando_out        = (r_estado == IDLE);
  assign iniciar_out           = (r_estado == INICIALIZAR);
  assign tem_ativo_out         = (r_estado == TEM_ATIVO);
  assign construir_caminho_out = (r_estado == CONSTRUIR);
  assign caminho_pronto_out    = (r_estado == PRONTO);
  assign erro_out              = (r_estado == ERRO);
  assign expandir_out          = r_exp;
  assign codigo_erro_out       = r_cod;
  assign iteracoes_out         = r_iter;

endmodule

// File: tb/tb_controlador_busca_multicanal.sv
// Bench for controlador_busca_multicanal: directed scenarios then
// random traffic, scored every cycle against a reference model.
module tb_controlador_busca_multicanal;

  localparam int N   = 4;
  localparam int IW  = 16;
  localparam int MXI = 3;
  localparam int TW  = 5;
  localparam int TMO = 16;

  // Reference-model phases (own numbering).
  localparam int F_OCIO = 0;
  localparam int F_INIC = 1;
  localparam int F_CHEC = 2;
  localparam int F_EXPA = 3;
  localparam int F_CONS = 4;
  localparam int F_PRON = 5;
  localparam int F_ERRO = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iniciar_in = 1'b0;
  logic          abortar_in = 1'b0;
  logic          tem_ativo_in = 1'b0;
  logic [N-1:0]  canal_habilitado_in = '0;
  logic [N-1:0]  lvv_pronto_in = '0;
  logic          caminho_pronto_in = 1'b0;
  logic          lido_in = 1'b0;
  logic          aguardando_out;
  logic          iniciar_out;
  logic          tem_ativo_out;
  logic [N-1:0]  expandir_out;
  logic          construir_caminho_out;
  logic          caminho_pronto_out;
  logic          erro_out;
  logic [1:0]    codigo_erro_out;
  logic [IW-1:0] iteracoes_out;

  controlador_busca_multicanal #(
    .N_CANAIS(N), .ITER_WIDTH(IW), .MAX_ITER(MXI),
    .TIMEOUT_WIDTH(TW), .TIMEOUT_CICLOS(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iniciar_in(iniciar_in), .abortar_in(abortar_in),
    .tem_ativo_in(tem_ativo_in),
    .canal_habilitado_in(canal_habilitado_in),
    .lvv_pronto_in(lvv_pronto_in),
    .caminho_pronto_in(caminho_pronto_in), .lido_in(lido_in),
    .aguardando_out(aguardando_out), .iniciar_out(iniciar_out),
    .tem_ativo_out(tem_ativo_out), .expandir_out(expandir_out),
    .construir_caminho_out(construir_caminho_out),
    .caminho_pronto_out(caminho_pronto_out), .erro_out(erro_out),
    .codigo_erro_out(codigo_erro_out), .iteracoes_out(iteracoes_out)
  );

  always #5 clk = ~clk;

  typedef logic [27:0] vec_t;
  vec_t fila[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ciclo = 0;

  // Model state.
  int   m_fase = F_OCIO;
  int   m_iter = 0;
  int   m_wd = 0;
  int   m_cod = 0;
  int   m_pend = 0;
  int   m_pulso = 0;

  function automatic bit cronometrada(int f);
    return f == F_INIC || f == F_EXPA || f == F_CONS;
  endfunction

  function automatic vec_t esperado();
    vec_t v;
    v = {m_fase == F_OCIO, m_fase == F_INIC, m_fase == F_CHEC,
         4'(m_pulso), m_fase == F_CONS, m_fase == F_PRON,
         m_fase == F_ERRO, 2'(m_cod), 16'(m_iter)};
    return v;
  endfunction

  task automatic modelo(bit ini, bit ab, bit ta, int msk,
                        int lvv, bit cp, bit ld);
    int nf;
    nf = m_fase;
    m_pulso = 0;
    if (ini) begin
      nf = F_INIC; m_iter = 0; m_cod = 0;
    end else if (ab && (cronometrada(m_fase) || m_fase == F_CHEC)) begin
      nf = F_ERRO; m_cod = 1;
    end else if (cronometrada(m_fase) && m_wd == TMO - 1) begin
      nf = F_ERRO; m_cod = 3;
    end else begin
      if (m_fase == F_INIC && ta) nf = F_CHEC;
      if (m_fase == F_CHEC) begin
        if (!ta) nf = F_CONS;
        else if (m_iter == MXI) begin nf = F_ERRO; m_cod = 2; end
        else if (msk == 0) begin nf = F_ERRO; m_cod = 0; end
        else begin
          nf = F_EXPA; m_iter++; m_pend = msk; m_pulso = msk;
        end
      end else if (m_fase == F_EXPA) begin
        m_pend = m_pend & ~lvv;
        if (m_pend == 0) nf = F_CHEC;
      end
      if (m_fase == F_CONS && cp) nf = F_PRON;
      if ((m_fase == F_PRON || m_fase == F_ERRO) && ld) nf = F_OCIO;
    end
    if (ini || nf != m_fase) m_wd = 0;
    else if (cronometrada(nf)) m_wd++;
    else m_wd = 0;
    m_fase = nf;
  endtask

  task automatic ciclo(bit rst, bit ini, bit ab, bit ta, int msk,
                       int lvv, bit cp, bit ld);
    rst_n = rst;
    iniciar_in = ini;
    abortar_in = ab;
    tem_ativo_in = ta;
    canal_habilitado_in = 4'(msk);
    lvv_pronto_in = 4'(lvv);
    caminho_pronto_in = cp;
    lido_in = ld;
    if (!rst) begin
      m_fase = F_OCIO; m_iter = 0; m_wd = 0;
      m_cod = 0; m_pend = 0; m_pulso = 0;
    end else begin
      modelo(ini, ab, ta, msk, lvv, cp, ld);
    end
    fila.push_back(esperado());
    @(negedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a full output vector.
  always @(negedge clk) begin
    vec_t got, exp;
    n_ciclo++;
    if (fila.size() > 0) begin
      exp = fila.pop_front();
      got = {aguardando_out, iniciar_out, tem_ativo_out,
             expandir_out, construir_caminho_out,
             caminho_pronto_out, erro_out, codigo_erro_out,
             iteracoes_out};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL saidas ciclo %0d: dut=%h esperado=%h",
                 n_ciclo, got, exp);
      end
    end
  end

  task automatic esperar(int n, bit ta);
    for (int i = 0; i < n; i++) ciclo(1, 0, 0, ta, 4'hF, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    // Reset.
    ciclo(0, 0, 0, 0, 0, 0, 0, 0);
    ciclo(0, 1, 1, 1, 4'hF, 4'hF, 1, 1);
    ciclo(1, 0, 0, 0, 0, 0, 0, 0);

    // Nominal: 3 expansions, staggered channel completion.
    ciclo(1, 1, 0, 0, 4'hF, 0, 0, 0);
    ciclo(1, 0, 0, 1, 4'hF, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      ciclo(1, 0, 0, 1, 4'hF, 0, 0, 0);
      ciclo(1, 0, 0, 1, 4'hF, 4'b0001, 0, 0);
      ciclo(1, 0, 0, 1, 4'hF, 4'b0010, 0, 0);
      ciclo(1, 0, 0, 1, 4'hF, 4'b0100, 0, 0);
      ciclo(1, 0, 0, 1, 4'hF, 4'b1000, 0, 0);
    end
    ciclo(1, 0, 0, 0, 4'hF, 0, 0, 0);
    ciclo(1, 0, 0, 0, 0, 0, 0, 0);
    ciclo(1, 0, 0, 0, 0, 0, 1, 0);
    ciclo(1, 0, 0, 0, 0, 0, 0, 0);
    ciclo(1, 0, 0, 0, 0, 0, 0, 1);

    // Mask 0101 with non-pending and partial pulses.
    ciclo(1, 1, 0, 0, 0, 0, 0, 0);
    ciclo(1, 0, 0, 1, 0, 0, 0, 0);
    ciclo(1, 0, 0, 1, 4'b0101, 0, 0, 0);
    ciclo(1, 0, 0, 1, 4'b0101, 4'b1010, 0, 0);
    ciclo(1, 0, 0, 1, 4'b0101, 4'b0001, 0, 0);
    ciclo(1, 0, 0, 1, 4'b0101, 4'b0001, 0, 0);
    ciclo(1, 0, 0, 1, 4'b0101, 4'b0100, 0, 0);
    // Abort in EXPANDIR.
    ciclo(1, 0, 0, 1, 4'b0011, 0, 0, 0);
    ciclo(1, 0, 1, 1, 4'b0011, 0, 0, 0);
    ciclo(1, 0, 0, 0, 0, 0, 0, 1);
    // Abort with iniciar the same cycle.
    ciclo(1, 1, 0, 0, 0, 0, 0, 0);
    ciclo(1, 0, 0, 1, 0, 0, 0, 0);
    ciclo(1, 0, 0, 1, 4'b1000, 0, 0, 0);
    ciclo(1, 1, 1, 1, 4'b1000, 0, 0, 0);

    // Iteration limit: tem_ativo always 1, pulses on entry.
    ciclo(1, 0, 0, 1, 4'hF, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      ciclo(1, 0, 0, 1, 4'hF, 0, 0, 0);
      ciclo(1, 0, 0, 1, 4'hF, 4'hF, 0, 0);
    end
    esperar(2, 1);
    ciclo(1, 0, 0, 0, 0, 0, 0, 1);

    // Watchdog in EXPANDIR.
    ciclo(1, 1, 0, 0, 0, 0, 0, 0);
    ciclo(1, 0, 0, 1, 0, 0, 0, 0);
    ciclo(1, 0, 0, 1, 4'b0110, 0, 0, 0);
    esperar(TMO + 3, 1);
    ciclo(1, 0, 0, 0, 0, 0, 0, 1);
    // No channel enabled.
    ciclo(1, 1, 0, 0, 0, 0, 0, 0);
    ciclo(1, 0, 0, 1, 0, 0, 0, 0);
    ciclo(1, 0, 0, 1, 0, 0, 0, 0);
    esperar(2, 1);
    // Watchdog in INICIALIZAR.
    ciclo(1, 1, 0, 0, 0, 0, 0, 0);
    esperar(TMO + 2, 0);

    // Reset in EXPANDIR.
    ciclo(1, 1, 0, 0, 0, 0, 0, 0);
    ciclo(1, 0, 0, 1, 0, 0, 0, 0);
    ciclo(1, 0, 0, 1, 4'hF, 0, 0, 0);
    ciclo(0, 0, 0, 1, 4'hF, 0, 0, 0);
    ciclo(1, 0, 0, 1, 4'hF, 4'hF, 0, 0);
    esperar(2, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, ini, ab, ta, cp, ld;
      int msk, lvv;
      r   = ($urandom_range(0, 299) != 0);
      ini = ($urandom_range(0, 29) == 0);
      ab  = ($urandom_range(0, 59) == 0);
      ta  = ($urandom_range(0, 99) < 85);
      msk = $urandom_range(0, 15);
      lvv = 0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 99) < 30) lvv |= (1 << b);
      cp  = ($urandom_range(0, 3) == 0);
      ld  = ($urandom_range(0, 2) == 0);
      ciclo(r, ini, ab, ta, msk, lvv, cp, ld);
    end

    @(negedge clk);
    #2;
    if (fila.size() != 0) begin
      n_err++;
      $display("FAIL fila: restantes=%0d esperado=0", fila.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
